// File: rtl/bus_pkg.sv
// Shared types and constants for the 8-bit processor bus initiator and its peripherals.
package bus_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  // Parked address while the bus is idle; must never decode to a peripheral.
  localparam logic [ADDR_W-1:0] IDLE_ADDR_DEFAULT = 8'hFF;

  localparam logic [ADDR_W-1:0] SEVSEG_BASE = 8'hD0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    TURN    = 3'd4
  } bus_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  localparam int REQ_W = $bits(bus_req_t);

endpackage

// File: rtl/bus_req_fifo.sv
// Synchronous show-ahead request FIFO; a push is accepted while full if a pop frees the slot in the same cycle.
module bus_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/bus_master_port.sv
// Initiator for the shared 8-bit register bus: runs client requests as write / registered-read cycles.
// Build option BUS_MASTER_FIFO_EN puts a FIFO_DEPTH-entry request FIFO in front of the sequencer.
module bus_master_port
  import bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] IDLE_ADDR  = IDLE_ADDR_DEFAULT,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_RDATA,
  inout  wire  [DATA_W-1:0] BUS_DATA,
  output logic [ADDR_W-1:0] BUS_ADDR,
  output logic              BUS_WE
);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end

  // Request handshake: a request transfers on a CLK edge where REQ_VALID && REQ_READY;
  // while REQ_VALID is high and REQ_READY low the client holds every request field stable.
  bus_state_t        r_state;
  logic [ADDR_W-1:0] r_bus_addr;
  logic              r_bus_we;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;

  bus_state_t        w_state_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_we_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;
  logic              w_rsp_valid_nxt;
  logic [DATA_W-1:0] w_rdata_nxt;
  logic              w_take;
  bus_req_t          w_src;

`ifdef BUS_MASTER_FIFO_EN
  logic     w_fifo_full;
  logic     w_fifo_empty;
  logic     w_push;
  bus_req_t w_fifo_head;

  assign w_take    = (r_state == IDLE) && !w_fifo_empty;
  assign REQ_READY = !RESET && (!w_fifo_full || w_take);
  assign w_push    = REQ_VALID && REQ_READY;
  assign w_src     = w_fifo_head;

  bus_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_req_fifo (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_push  (w_push),
    .i_data  ({REQ_WE, REQ_ADDR, REQ_WDATA}),
    .i_pop   (w_take),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );
`else
  assign REQ_READY = !RESET && (r_state == IDLE);
  assign w_take    = REQ_VALID && REQ_READY;
  assign w_src     = '{we: REQ_WE, addr: REQ_ADDR, wdata: REQ_WDATA};
`endif

  // The master drives data only while the write strobe is up; every other cycle it is released.
  assign BUS_DATA  = r_bus_we ? r_wdata : {DATA_W{1'bz}};
  assign BUS_ADDR  = r_bus_addr;
  assign BUS_WE    = r_bus_we;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_RDATA = r_rsp_rdata;

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_bus_addr;
    w_we_nxt        = r_bus_we;
    w_wdata_nxt     = r_wdata;
    w_rsp_valid_nxt = 1'b0;
    w_rdata_nxt     = r_rsp_rdata;
    case (r_state)
      IDLE: begin
        if (w_take) begin
          w_addr_nxt = w_src.addr;
          w_we_nxt   = w_src.we;
          if (w_src.we) begin
            w_wdata_nxt = w_src.wdata;
            w_state_nxt = WR;
          end else begin
            w_state_nxt = RD_ADDR;
          end
        end
      end
      WR: begin
        w_addr_nxt  = IDLE_ADDR;
        w_we_nxt    = 1'b0;
        w_state_nxt = IDLE;
      end
      RD_ADDR: w_state_nxt = RD_DATA;
      RD_DATA: begin
        // Peripheral data is registered, so it is valid only in this second address cycle.
        w_rdata_nxt     = BUS_DATA;
        w_rsp_valid_nxt = 1'b1;
        w_addr_nxt      = IDLE_ADDR;
        w_state_nxt     = TURN;
      end
      TURN:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_bus_addr  <= IDLE_ADDR;
      r_bus_we    <= 1'b0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_bus_addr  <= w_addr_nxt;
      r_bus_we    <= w_we_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port with a seven-segment register bank model (0xD0-0xD5, registered reads).
`timescale 1ns/1ps
module tb_bus_master_port;
  import bus_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [7:0] bus_addr;
  logic       bus_we;
  wire  [7:0] bus_data;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int contention_cnt = 0;

  logic [7:0] bank    [0:5] = '{default: 8'h00};
  logic [7:0] ref_mem [0:5] = '{default: 8'h00};
  logic       bank_oe = 1'b0;
  logic [7:0] bank_q = 8'h00;
  logic [7:0] exp_q[$];

  bus_master_port dut (
    .CLK       (clk),
    .RESET     (rst),
    .REQ_VALID (req_valid),
    .REQ_READY (req_ready),
    .REQ_WE    (req_we),
    .REQ_ADDR  (req_addr),
    .REQ_WDATA (req_wdata),
    .RSP_VALID (rsp_valid),
    .RSP_RDATA (rsp_rdata),
    .BUS_DATA  (bus_data),
    .BUS_ADDR  (bus_addr),
    .BUS_WE    (bus_we)
  );

  // ---------------- clock / reset / peripheral model ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit in_bank(input logic [7:0] a);
    return (a >= SEVSEG_BASE) && (a <= SEVSEG_BASE + 8'd5);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      bank_oe <= 1'b0;
    end else begin
      bank_oe <= !bus_we && in_bank(bus_addr);
      bank_q  <= in_bank(bus_addr) ? bank[3'(bus_addr - SEVSEG_BASE)] : 8'h00;
      if (bus_we && in_bank(bus_addr)) bank[3'(bus_addr - SEVSEG_BASE)] <= bus_data;
    end
  end
  assign bus_data = bank_oe ? bank_q : 8'hzz;

  always @(negedge clk) if (bus_we && bank_oe) contention_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send(input logic we, input logic [7:0] a, input logic [7:0] d, output int acc);
    int waited;
    waited = 0;
    acc = -1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    while (!req_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      tests_run++; tests_failed++;
      $display("FAIL send_timeout: ready=%0b after %0d cycles, required 1", req_ready, waited);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(output logic [7:0] d, output int c, output bit got);
    got = 1'b0; d = 8'h00; c = -1;
    for (int i = 0; i < 12 && !got; i++) begin
      if (rsp_valid) begin
        got = 1'b1; d = rsp_rdata; c = cyc;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++; if (bus_addr !== 8'hFF) begin tests_failed++; $display("FAIL rst_addr: got %0h required ff", bus_addr); end
    tests_run++; if (bus_we !== 1'b0) begin tests_failed++; $display("FAIL rst_we: got %0b required 0", bus_we); end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_rsp_valid: got %0b required 0", rsp_valid); end
    tests_run++; if (rsp_rdata !== 8'h00) begin tests_failed++; $display("FAIL rst_rdata: got %0h required 00", rsp_rdata); end
    tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_ready_in_reset: got %0b required 0", req_ready); end
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_ready_after: got %0b required 1", req_ready); end
  endtask

  task automatic test_write();
    int acc, c; logic [7:0] d; bit got;
    send(1'b1, 8'hD0, 8'h5A, acc);
    ref_mem[0] = 8'h5A;
    tests_run++; if (bus_we !== 1'b1 || bus_addr !== 8'hD0) begin tests_failed++; $display("FAIL wr_cycle: we=%0b addr=%0h required 1/d0", bus_we, bus_addr); end
    tests_run++; if (bus_data !== 8'h5A) begin tests_failed++; $display("FAIL wr_data: got %0h required 5a", bus_data); end
    @(negedge clk);
    tests_run++; if (bus_we !== 1'b0 || bus_addr !== 8'hFF) begin tests_failed++; $display("FAIL wr_release: we=%0b addr=%0h required 0/ff", bus_we, bus_addr); end
    tests_run++; if (bank[0] !== 8'h5A) begin tests_failed++; $display("FAIL wr_bank0: got %0h required 5a", bank[0]); end
    send(1'b0, 8'hD0, 8'h00, acc);
    wait_rsp(d, c, got);
    tests_run++; if (!got || d !== 8'h5A) begin tests_failed++; $display("FAIL wr_readback: got=%0b data=%0h required 5a", got, d); end
  endtask

  task automatic test_read();
    int acc, c; logic [7:0] d; bit got;
    send(1'b1, 8'hD2, 8'h3C, acc);
    ref_mem[2] = 8'h3C;
    @(negedge clk);
    send(1'b0, 8'hD2, 8'h00, acc);
    tests_run++; if (bus_we !== 1'b0 || bus_addr !== 8'hD2) begin tests_failed++; $display("FAIL rd_addr_phase: we=%0b addr=%0h required 0/d2", bus_we, bus_addr); end
    wait_rsp(d, c, got);
    tests_run++; if (!got || c - acc != 2) begin tests_failed++; $display("FAIL rd_latency: got=%0b cycles=%0d required 2 after accept cycle", got, c - acc); end
    tests_run++; if (d !== 8'h3C) begin tests_failed++; $display("FAIL rd_data: got %0h required 3c", d); end
    tests_run++; if (req_ready !== 1'b0 || bus_addr !== 8'hFF) begin tests_failed++; $display("FAIL rd_turn: ready=%0b addr=%0h required 0/ff", req_ready, bus_addr); end
    @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin tests_failed++; $display("FAIL rd_pulse_end: valid=%0b ready=%0b required 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_read_then_write();
    int acc_r, acc_w, c; logic [7:0] d; bit got;
    send(1'b0, 8'hD1, 8'h00, acc_r);
    wait_rsp(d, c, got);
    tests_run++; if (!got || d !== ref_mem[1]) begin tests_failed++; $display("FAIL rw_read: got=%0b data=%0h required %0h", got, d, ref_mem[1]); end
    send(1'b1, 8'hD3, 8'h11, acc_w);
    ref_mem[3] = 8'h11;
    tests_run++; if (acc_w - acc_r != 4) begin tests_failed++; $display("FAIL rw_turn_gap: got %0d cycles required 4", acc_w - acc_r); end
    tests_run++; if (bus_data !== 8'h11) begin tests_failed++; $display("FAIL rw_wdata: got %0h required 11", bus_data); end
    @(negedge clk);
    tests_run++; if (bank[3] !== 8'h11) begin tests_failed++; $display("FAIL rw_bank3: got %0h required 11", bank[3]); end
    tests_run++; if (contention_cnt != 0) begin tests_failed++; $display("FAIL rw_contention: got %0d cycles required 0", contention_cnt); end
  endtask

  task automatic test_back_to_back();
    int acc, prev;
    prev = -1;
    for (int i = 0; i < 3; i++) begin
      send(1'b1, SEVSEG_BASE + 8'(i), 8'(i + 1), acc);
      ref_mem[i] = 8'(i + 1);
      if (prev >= 0) begin
        tests_run++; if (acc - prev != 2) begin tests_failed++; $display("FAIL b2b_gap%0d: got %0d cycles required 2", i, acc - prev); end
      end
      prev = acc;
      @(negedge clk);
      tests_run++; if (bus_addr !== 8'hFF || bus_we !== 1'b0) begin tests_failed++; $display("FAIL b2b_park%0d: addr=%0h we=%0b required ff/0", i, bus_addr, bus_we); end
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (bank[i] !== 8'(i + 1)) begin tests_failed++; $display("FAIL b2b_bank%0d: got %0h required %0h", i, bank[i], i + 1); end
    end
  endtask

  task automatic test_reset_mid_read();
    int acc, seen;
    send(1'b0, 8'hD2, 8'h00, acc);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if (bus_addr !== 8'hFF || bus_we !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_bus: addr=%0h we=%0b required ff/0", bus_addr, bus_we); end
    tests_run++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_flags: valid=%0b ready=%0b required 0/0", rsp_valid, req_ready); end
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_rst_ready: got %0b required 1", req_ready); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL mid_rst_no_rsp: got %0d pulses required 0", seen); end
  endtask

  task automatic test_random();
    int acc, prev, c; logic [7:0] d, a, wd, exp_d; bit got, we, mapped, prev_we;
    prev = -1; prev_we = 1'b0;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      mapped = ($urandom_range(0, 7) != 0);
      a = mapped ? SEVSEG_BASE + 8'($urandom_range(0, 5)) : 8'($urandom_range(0, 8'hCF));
      wd = 8'($urandom);
      send(we, a, wd, acc);
      if (prev >= 0) begin
        tests_run++; if (acc - prev != (prev_we ? 2 : 4)) begin tests_failed++; $display("FAIL rnd_gap%0d: got %0d cycles required %0d", n, acc - prev, prev_we ? 2 : 4); end
      end
      prev = acc; prev_we = we;
      if (we) begin
        if (mapped) ref_mem[3'(a - SEVSEG_BASE)] = wd;
        tests_run++; if (bus_data !== wd || bus_addr !== a) begin tests_failed++; $display("FAIL rnd_wr%0d: data=%0h addr=%0h required %0h/%0h", n, bus_data, bus_addr, wd, a); end
      end else begin
        if (mapped) exp_q.push_back(ref_mem[3'(a - SEVSEG_BASE)]);
        wait_rsp(d, c, got);
        tests_run++; if (!got || c - acc != 2) begin tests_failed++; $display("FAIL rnd_rsp%0d: got=%0b cycles=%0d required 2", n, got, c - acc); end
        if (mapped) begin
          exp_d = exp_q.pop_front();
          tests_run++; if (d !== exp_d) begin tests_failed++; $display("FAIL rnd_rd%0d: addr=%0h got %0h required %0h", n, a, d, exp_d); end
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      tests_run++; if (bank[i] !== ref_mem[i]) begin tests_failed++; $display("FAIL rnd_bank%0d: got %0h required %0h", i, bank[i], ref_mem[i]); end
    end
  endtask

`ifdef BUS_MASTER_FIFO_EN
  task automatic test_fifo();
    int acc, got_n; bit held; logic [7:0] exp_d;
    for (int i = 0; i < 6; i++) begin
      ref_mem[i] = 8'($urandom);
      send(1'b1, SEVSEG_BASE + 8'(i), ref_mem[i], acc);
    end
    repeat (20) @(negedge clk);
    for (int i = 0; i < 6; i++) exp_q.push_back(ref_mem[i]);
    got_n = 0; held = 1'b0;
    fork
      for (int i = 0; i < 6; i++) send(1'b0, SEVSEG_BASE + 8'(i), 8'h00, acc);
      for (int t = 0; t < 200 && got_n < 6; t++) begin
        @(negedge clk);
        if (req_valid && !req_ready) held = 1'b1;
        if (rsp_valid) begin
          exp_d = exp_q.pop_front();
          got_n++;
          tests_run++; if (rsp_rdata !== exp_d) begin tests_failed++; $display("FAIL fifo_order%0d: got %0h required %0h", got_n, rsp_rdata, exp_d); end
        end
      end
    join
    tests_run++; if (got_n != 6) begin tests_failed++; $display("FAIL fifo_count: got %0d responses required 6", got_n); end
    tests_run++; if (!held) begin tests_failed++; $display("FAIL fifo_full: ready never dropped, required a hold-off"); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef BUS_MASTER_FIFO_EN
    test_fifo();
`else
    test_write();
    test_read();
    test_read_then_write();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
